// File: rtl/calc_core_pkg.sv
// Shared opcode encodings and FSM state type for the calc_core accumulator CPU.
package calc_core_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDX  = 4'h1;
    localparam logic [3:0] OP_LDY  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_MOVZ = 4'h9;
    localparam logic [3:0] OP_MOVX = 4'hA;
    localparam logic [3:0] OP_CLR  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_JC   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: a is the accumulator (Y), b is X or the LDY immediate.
module calc_alu
    import calc_core_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Subtraction as a + ~b + 1 so the top bit is the no-borrow (a >= b) flag.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LDY:  result = b;
            OP_ADD:  begin result = sum_s[DATA_W-1:0];  carry = sum_s[DATA_W];  end
            OP_SUB:  begin result = diff_s[DATA_W-1:0]; carry = diff_s[DATA_W]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_CLR:  result = {DATA_W{1'b0}};
            default: result = a;
        endcase
        zero = (result == {DATA_W{1'b0}});
    end

endmodule

// File: rtl/calc_core.sv
// Multi-cycle fetch/decode/execute X/Y/Z accumulator core reading a synchronous ROM.
// Define CALC_CORE_BRANCH_EN to enable JMP/JZ/JC; otherwise those opcodes act as NOP.
module calc_core
    import calc_core_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic [ADDR_W-1:0]      instr_addr,
    input  logic [OP_W+DATA_W-1:0] instr_data,
    output logic [DATA_W-1:0]      reg_x,
    output logic [DATA_W-1:0]      reg_y,
    output logic [DATA_W-1:0]      reg_z,
    output logic [ADDR_W-1:0]      pc,
    output logic                   flag_z,
    output logic                   flag_c,
    output logic                   busy,
    output logic                   halted
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [OP_W+DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]      pc_q, pc_d, pc_inc_s;
    logic [DATA_W-1:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic                   fz_q, fz_d, fc_q, fc_d;
    logic                   busy_q, busy_d, halted_q, halted_d;

    logic [3:0]             op_s;
    logic [DATA_W-1:0]      imm_s;
    logic [DATA_W-1:0]      alu_b_s, alu_result_s;
    logic                   alu_carry_s, alu_zero_s;

    assign op_s     = ir_q[DATA_W +: 4];
    assign imm_s    = ir_q[DATA_W-1:0];
    assign pc_inc_s = pc_q + PC_ONE;
    assign alu_b_s  = (op_s == OP_LDY) ? imm_s : x_q;

`ifdef CALC_CORE_BRANCH_EN
    logic [ADDR_W-1:0] jmp_tgt_s;

    // Jump target: low ADDR_W bits of the immediate, zero-extended if narrower.
    if (ADDR_W <= DATA_W) begin : g_tgt_trunc
        assign jmp_tgt_s = imm_s[ADDR_W-1:0];
    end else begin : g_tgt_ext
        assign jmp_tgt_s = {{(ADDR_W-DATA_W){1'b0}}, imm_s};
    end
`endif

    calc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (y_q),
        .b      (alu_b_s),
        .op     (op_s),
        .result (alu_result_s),
        .carry  (alu_carry_s),
        .zero   (alu_zero_s)
    );

    // Next-state logic for the FSM, IR, PC, registers and flags.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
                else     state_d = S_IDLE;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = instr_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc_s;
                case (op_s)
                    OP_LDX:  x_d = imm_s;
                    OP_ADD, OP_SUB: begin
                        y_d  = alu_result_s;
                        fz_d = alu_zero_s;
                        fc_d = alu_carry_s;
                    end
                    OP_LDY, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CLR: begin
                        y_d  = alu_result_s;
                        fz_d = alu_zero_s;
                    end
                    OP_MOVZ: z_d = y_q;
                    OP_MOVX: x_d = y_q;
`ifdef CALC_CORE_BRANCH_EN
                    OP_JMP:  pc_d = jmp_tgt_s;
                    OP_JZ: begin
                        if (fz_q) pc_d = jmp_tgt_s;
                        else      pc_d = pc_inc_s;
                    end
                    OP_JC: begin
                        if (fc_q) pc_d = jmp_tgt_s;
                        else      pc_d = pc_inc_s;
                    end
`endif
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: pc_d = pc_inc_s;
                endcase
            end
            S_HALT: begin
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = {ADDR_W{1'b0}};
                end else begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
        halted_d = (state_d == S_HALT);
    end

    // State registers; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ir_q     <= {(OP_W+DATA_W){1'b0}};
            pc_q     <= {ADDR_W{1'b0}};
            x_q      <= {DATA_W{1'b0}};
            y_q      <= {DATA_W{1'b0}};
            z_q      <= {DATA_W{1'b0}};
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            fz_q     <= fz_d;
            fc_q     <= fc_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign reg_x      = x_q;
    assign reg_y      = y_q;
    assign reg_z      = z_q;
    assign flag_z     = fz_q;
    assign flag_c     = fc_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule
